add_aligner: RTL and testbench
==============================

Name: add_aligner

Overview:
- Pre-add operand alignment for the FP add/sub datapath. It is the inverse of the post-add normaliser, which shifts left and decrements the exponent.
- Compares exponents, swaps so the larger-exponent operand is "big", and right-shifts the small mantissa by the exponent difference.
- Shifted-out bits are collected into guard/round/sticky.
- Iterative (STEP bits per cycle) with valid/ready on both sides. It sits between operand unpack and the mantissa adder.

Parameters:
- STEP, 8, maximum right-shift distance per SHIFT cycle; legal values 1..27.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- a_e  in  8  operand A biased exponent
- a_m  in  24  operand A mantissa, hidden bit at [23]
- b_e  in  8  operand B biased exponent
- b_m  in  24  operand B mantissa, hidden bit at [23]
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- out_e  out  8  common exponent, max(a_e, b_e)
- out_big_m  out  27  {big mantissa, 3'b000}
- out_small_m  out  27  aligned small mantissa {m[23:0], G, R, S}
- out_swap  out  1  1 = big operand is B

Behaviour:
- Reset: synchronous, on clk when rst_n=0.
  - State returns to IDLE.
  - in_ready=0 during reset; it becomes 1 in the first cycle after release.
  - out_valid=0; out_e, out_big_m, out_small_m, out_swap = 0.
  - Reset mid-SHIFT or mid-DONE drops the transaction with no output.
- FSM: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE, on in_valid & in_ready, registers the operands:
  - swap = (b_e > a_e); on equal exponents, A is big and swap=0.
  - out_e = larger exponent.
  - big_m = {larger-exponent mantissa, 3'b0}; small_m = {other mantissa, 3'b0}.
  - rem = min(|a_e - b_e|, 27), using a 9-bit difference.
  - Next state: DONE if rem==0, else SHIFT.
- SHIFT, each cycle:
  - amt = min(rem, STEP).
  - small_m = small_m >> amt; new bit0 = OR of the old bit0 and all bits shifted out (sticky is never cleared).
  - rem -= amt; go to DONE when rem reaches 0.
- DONE: outputs held stable while out_valid & !out_ready. On out_ready, go to IDLE; a new input is not accepted in the same cycle.
- Latency from accept edge to out_valid rising:
  - 1 cycle if diff=0.
  - Otherwise 1 + ceil(min(diff,27)/STEP) cycles.
  - Throughput: at most one operation per (latency+1) cycles.
- Boundaries:
  - diff ≥ 27: small_m = 27'd0 with bit0 = |mantissa (all sticky).
  - Zero mantissa: never sets sticky.
  - in_valid while busy: ignored (in_ready=0). The source must hold the operands until accepted.
  - Exponent 0 and 255 are treated numerically; special values are handled upstream.

Optional Feature:
- Macro: ALIGN_EARLY_OUT_EN.
- Defined: when diff ≥ 27 at accept, go IDLE→DONE directly, loading small_m = {26'd0, |small mantissa}. Latency 1 cycle.
- Undefined: the diff ≥ 27 case iterates through SHIFT like any other value (ceil(27/STEP) cycles).
- Output values are identical either way; only latency differs.

Decomposition:
- Shared package fp_pkg:
  - EXP_W=8, MAN_W=24, GRS_W=3, ALIGN_W=27 constants.
  - Typedef align_state_e {IDLE, SHIFT, DONE}.
  - Typedef fp_unpacked_t {e, m}.
- One natural sub-module: sticky_rshift, a combinational right shift by amt (≤ STEP) with OR-reduced sticky into bit0. Instantiated once.

Test Plan:
- Equal exponents: a_e=0x80, a_m=0xC00000, b_e=0x80, b_m=0xA00000 → out_valid 1 cycle after accept; out_e=0x80, out_big_m=0x6000000, out_small_m=0x5000000, swap=0.
- Swap + short shift: a_e=0x7E, a_m=0x800000, b_e=0x81, b_m=0xC00000 → swap=1, out_e=0x81, out_big_m=0x6000000, out_small_m=0x0800000, latency 2 (STEP=8).
- Sticky: a_e=0x8A, a_m=0x800000, b_e=0x80, b_m=0x800001 → out_small_m=0x0010001, latency 3.
- Huge diff: a_e=0xC0, b_e=0x10, b_m=0x800000 → out_small_m=0x0000001.
  - Latency 5 without the macro, 1 with ALIGN_EARLY_OUT_EN.
  - Repeat with b_m=0 → out_small_m=0.
- Backpressure/reset: hold out_ready=0 for 5 cycles → outputs stable, in_ready=0. Then assert rst_n=0 during a SHIFT → next cycle out_valid=0 and all outputs 0; first cycle after release in_ready=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP datapath constants and types for the single-precision add/sub path.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 24;
  localparam int unsigned GRS_W   = 3;
  localparam int unsigned ALIGN_W = MAN_W + GRS_W;
  // Wide enough to hold any shift distance up to ALIGN_W.
  localparam int unsigned AMT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_e;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_unpacked_t;

endpackage

// File: rtl/sticky_rshift.sv
// Combinational right shift that folds every bit shifted out, plus the old bit 0,
// into bit 0 of the result.
module sticky_rshift
  import fp_pkg::*;
(
  input  logic [ALIGN_W-1:0] din_i,
  input  logic [AMT_W-1:0]   amt_i,
  output logic [ALIGN_W-1:0] dout_o
);

  logic sticky;

  always_comb begin
    sticky = din_i[0];
    for (int unsigned i = 0; i < ALIGN_W; i++) begin
      if (i < 32'(amt_i)) begin
        sticky = sticky | din_i[i];
      end
    end
    dout_o    = din_i >> amt_i;
    dout_o[0] = dout_o[0] | sticky;
  end

endmodule

// File: rtl/add_aligner.sv
// Pre-add operand aligner: swaps so the larger exponent is "big", then right-shifts the small
// mantissa STEP bits per cycle with guard/round/sticky. ALIGN_EARLY_OUT_EN skips SHIFT for diff>=27.
module add_aligner
  import fp_pkg::*;
#(
  parameter int unsigned STEP = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   a_e,
  input  logic [MAN_W-1:0]   a_m,
  input  logic [EXP_W-1:0]   b_e,
  input  logic [MAN_W-1:0]   b_m,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_e,
  output logic [ALIGN_W-1:0] out_big_m,
  output logic [ALIGN_W-1:0] out_small_m,
  output logic               out_swap
);

  localparam logic [AMT_W-1:0] StepAmt  = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] MaxShift = AMT_W'(ALIGN_W);

  align_state_e        state_q, state_d;
  logic [EXP_W-1:0]    e_q, e_d;
  logic [ALIGN_W-1:0]  big_q, big_d;
  logic [ALIGN_W-1:0]  small_q, small_d;
  logic                swap_q, swap_d;
  logic [AMT_W-1:0]    rem_q, rem_d;

  fp_unpacked_t        op_a, op_b, op_big, op_small;
  logic                swap_in;
  logic [EXP_W:0]      diff;
  logic [AMT_W-1:0]    rem_init;
  logic [AMT_W-1:0]    amt;
  logic [ALIGN_W-1:0]  shifted;

  assign op_a     = '{e: a_e, m: a_m};
  assign op_b     = '{e: b_e, m: b_m};
  assign swap_in  = (b_e > a_e);
  assign op_big   = swap_in ? op_b : op_a;
  assign op_small = swap_in ? op_a : op_b;
  assign diff     = {1'b0, op_big.e} - {1'b0, op_small.e};
  assign rem_init = (diff >= (EXP_W+1)'(ALIGN_W)) ? MaxShift : diff[AMT_W-1:0];
  assign amt      = (rem_q < StepAmt) ? rem_q : StepAmt;

  sticky_rshift u_sticky_rshift (
    .din_i  (small_q),
    .amt_i  (amt),
    .dout_o (shifted)
  );

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    big_d   = big_q;
    small_d = small_q;
    swap_d  = swap_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          e_d     = op_big.e;
          big_d   = {op_big.m, {GRS_W{1'b0}}};
          small_d = {op_small.m, {GRS_W{1'b0}}};
          swap_d  = swap_in;
          rem_d   = rem_init;
          state_d = (rem_init == '0) ? DONE : SHIFT;
`ifdef ALIGN_EARLY_OUT_EN
          // Everything shifts out: the result is just the sticky of the mantissa.
          if (rem_init == MaxShift) begin
            small_d = {{(ALIGN_W-1){1'b0}}, |op_small.m};
            rem_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        small_d = shifted;
        rem_d   = rem_q - amt;
        if (rem_q == amt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_q     <= '0;
      big_q   <= '0;
      small_q <= '0;
      swap_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      big_q   <= big_d;
      small_q <= small_d;
      swap_q  <= swap_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready    = rst_n & (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_e       = e_q;
  assign out_big_m   = big_q;
  assign out_small_m = small_q;
  assign out_swap    = swap_q;

endmodule

// File: tb/tb_add_aligner.sv
// Self-checking bench for add_aligner: directed cases plus random operand pairs
// against an arithmetic reference of alignment, sticky and latency.
module tb_add_aligner;

  localparam int unsigned STEP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_e, b_e;
  logic [23:0] a_m, b_m;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_e;
  logic [26:0] out_big_m;
  logic [26:0] out_small_m;
  logic        out_swap;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  add_aligner #(
    .STEP(STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_e        (a_e),
    .a_m        (a_m),
    .b_e        (b_e),
    .b_m        (b_m),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_e      (out_e),
    .out_big_m  (out_big_m),
    .out_small_m(out_small_m),
    .out_swap   (out_swap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Aligned small mantissa: ideal right shift of {m,000}, with any lost bit ORed into bit 0.
  function automatic logic [26:0] ref_small(input logic [23:0] m, input int d);
    logic [63:0] full, lo, sh;
    full = {37'd0, m, 3'b000};
    if (d >= 27) return {26'd0, |m};
    lo = full & ((64'd1 << d) - 64'd1);
    sh = full >> d;
    return sh[26:0] | {26'd0, |lo};
  endfunction

  function automatic int ref_lat(input int d);
    int r;
    r = (d > 27) ? 27 : d;
    if (r == 0) return 1;
`ifdef ALIGN_EARLY_OUT_EN
    if (r == 27) return 1;
`endif
    return 1 + (r + int'(STEP) - 1) / int'(STEP);
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ae, input logic [23:0] am,
                        input logic [7:0] be, input logic [23:0] bm, input int hold);
    int          d, lat, wait_n;
    logic        sw;
    logic [7:0]  ee;
    logic [26:0] eb, es;
    sw = (be > ae);
    d  = int'(ae) - int'(be);
    if (d < 0) d = -d;
    ee = sw ? be : ae;
    eb = {(sw ? bm : am), 3'b000};
    es = ref_small(sw ? am : bm, d);

    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a_e = ae; a_m = am; b_e = be; b_m = bm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble the inputs so the outputs must come from registered operands.
    a_e = 8'($urandom); a_m = 24'($urandom); b_e = 8'($urandom); b_m = 24'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(ref_lat(d)));
    chk({tag, ".out_e"}, 32'(out_e), 32'(ee));
    chk({tag, ".big_m"}, 32'(out_big_m), 32'(eb));
    chk({tag, ".small_m"}, 32'(out_small_m), 32'(es));
    chk({tag, ".swap"}, 32'(out_swap), 32'(sw));
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_small"}, 32'(out_small_m), 32'(es));
      chk({tag, ".hold_e"}, 32'(out_e), 32'(ee));
      chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  ae, be;
    logic [23:0] am, bm;
    int          t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_e = '0; a_m = '0; b_e = '0; b_m = '0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_e", 32'(out_e), 32'd0);
    chk("rst.big_m", 32'(out_big_m), 32'd0);
    chk("rst.small_m", 32'(out_small_m), 32'd0);
    chk("rst.swap", 32'(out_swap), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_op("equal", 8'h80, 24'hC00000, 8'h80, 24'hA00000, 5);
    run_op("swap", 8'h7E, 24'h800000, 8'h81, 24'hC00000, 1);
    run_op("sticky", 8'h8A, 24'h800000, 8'h80, 24'h800001, 0);
    run_op("huge", 8'hC0, 24'h800000, 8'h10, 24'h800000, 2);
    run_op("huge_zero", 8'hC0, 24'h800000, 8'h10, 24'h000000, 0);
    run_op("diff27", 8'h1B, 24'hFFFFFF, 8'h00, 24'hFFFFFF, 0);
    run_op("exp_ends", 8'h00, 24'h000000, 8'hFF, 24'h123456, 0);

    // Reset in the middle of SHIFT drops the transaction.
    while (!in_ready) @(negedge clk);
    a_e = 8'h94; a_m = 24'h812345; b_e = 8'h80; b_m = 24'hFFFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst.shifting", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.out_e", 32'(out_e), 32'd0);
    chk("midrst.big_m", 32'(out_big_m), 32'd0);
    chk("midrst.small_m", 32'(out_small_m), 32'd0);
    chk("midrst.swap", 32'(out_swap), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst.release_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst.dropped", 32'(out_valid), 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      ae = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        t = int'(ae) + int'($urandom_range(0, 60)) - 30;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        be = 8'(t);
      end else begin
        be = 8'($urandom_range(0, 255));
      end
      am = ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
      bm = ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
      run_op("rand", ae, am, be, bm, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
